// File: rtl/issue_queue_unit_if.sv
// Bundles the dispatch, forwarding and issue signals of the issue queue.
// The master modport drives dispatch and forwarding; the slave modport is the queue.
interface issue_queue_unit_if;
  logic         write_enable;
  logic [5:0]   phys_rd;
  logic [5:0]   phys_rs1;
  logic [5:0]   phys_rs2;
  logic [31:0]  phys_rs1_val;
  logic [31:0]  phys_rs2_val;
  logic [6:0]   opcode;
  logic [31:0]  immediate;
  logic [5:0]   ROB_entry_index;

  logic         fwd_enable;
  logic [5:0]   fwd_rd_funct_unit0;
  logic [5:0]   fwd_rd_funct_unit1;
  logic [5:0]   fwd_rd_funct_unit2;
  logic [31:0]  fwd_rd_val_funct_unit0;
  logic [31:0]  fwd_rd_val_funct_unit1;
  logic [31:0]  fwd_rd_val_funct_unit2;

  logic [128:0] issued_funct_unit0;
  logic [128:0] issued_funct_unit1;
  logic [128:0] issued_funct_unit2;
  logic         funct0_enable;
  logic         funct1_enable;
  logic         funct2_enable;
  logic         issue_queue_full;

  modport master (
    output write_enable, phys_rd, phys_rs1, phys_rs2, phys_rs1_val, phys_rs2_val,
           opcode, immediate, ROB_entry_index,
           fwd_enable, fwd_rd_funct_unit0, fwd_rd_funct_unit1, fwd_rd_funct_unit2,
           fwd_rd_val_funct_unit0, fwd_rd_val_funct_unit1, fwd_rd_val_funct_unit2,
    input  issued_funct_unit0, issued_funct_unit1, issued_funct_unit2,
           funct0_enable, funct1_enable, funct2_enable, issue_queue_full
  );

  modport slave (
    input  write_enable, phys_rd, phys_rs1, phys_rs2, phys_rs1_val, phys_rs2_val,
           opcode, immediate, ROB_entry_index,
           fwd_enable, fwd_rd_funct_unit0, fwd_rd_funct_unit1, fwd_rd_funct_unit2,
           fwd_rd_val_funct_unit0, fwd_rd_val_funct_unit1, fwd_rd_val_funct_unit2,
    output issued_funct_unit0, issued_funct_unit1, issued_funct_unit2,
           funct0_enable, funct1_enable, funct2_enable, issue_queue_full
  );
endinterface

// File: rtl/issue_queue_unit.sv
// Out-of-order issue queue: holds dispatched instructions, captures forwarded
// operands and issues up to three ready entries per cycle, oldest slot first.
module issue_queue_unit #(
  parameter int NUM_FUNCTIONAL_UNITS = 3,
  parameter int NUM_PHYSICAL_REGS    = 64,
  parameter int NUM_INSTRUCTIONS     = 64,
  parameter int ENTRY_SIZE           = 129
) (
  input  logic              clk,
  input  logic              reset_n,
  issue_queue_unit_if.slave iq
);

  localparam int TAG_W = $clog2(NUM_PHYSICAL_REGS);
  localparam int IDX_W = $clog2(NUM_INSTRUCTIONS);
  localparam int NFU   = NUM_FUNCTIONAL_UNITS;

  localparam int RS1_LSB  = 117;
  localparam int RS1V_LSB = 85;
  localparam int RS1R_BIT = 84;
  localparam int RS2_LSB  = 78;
  localparam int RS2V_LSB = 46;
  localparam int RS2R_BIT = 45;

  logic [NUM_INSTRUCTIONS-1:0] valid_q, valid_d;
  logic [ENTRY_SIZE-1:0]       payload_q [NUM_INSTRUCTIONS];
  logic [ENTRY_SIZE-1:0]       payload_d [NUM_INSTRUCTIONS];
  logic [NFU-1:0]              enable_q, enable_d;
  logic [ENTRY_SIZE-1:0]       issued_q [NFU];
  logic [ENTRY_SIZE-1:0]       issued_d [NFU];

  logic [NFU-1:0][TAG_W-1:0]   fwd_tag;
  logic [NFU-1:0][31:0]        fwd_val;

  logic [NUM_INSTRUCTIONS-1:0] ready_vec;
  logic [NUM_INSTRUCTIONS-1:0] remaining;
  logic [NFU-1:0]              sel_valid;
  logic [NFU-1:0][IDX_W-1:0]   sel_idx;
  logic                        free_valid;
  logic [IDX_W-1:0]            free_idx;
  logic [ENTRY_SIZE-1:0]       new_entry;
  logic [32:0]                 new_op1, new_op2;
  logic [32:0]                 cur_op1, cur_op2;

  assign fwd_tag = {iq.fwd_rd_funct_unit2, iq.fwd_rd_funct_unit1, iq.fwd_rd_funct_unit0};
  assign fwd_val = {iq.fwd_rd_val_funct_unit2, iq.fwd_rd_val_funct_unit1,
                    iq.fwd_rd_val_funct_unit0};

  // Returns {ready, value}; scanning FU2 down to FU0 lets the lowest FU win a tie.
  function automatic logic [32:0] resolve_operand(
    input logic [TAG_W-1:0]          tag,
    input logic                      rdy,
    input logic [31:0]               val,
    input logic                      en,
    input logic [NFU-1:0][TAG_W-1:0] ftag,
    input logic [NFU-1:0][31:0]      fval
  );
    logic [32:0] r;
    r = {rdy, val};
    if (en && !rdy) begin
      for (int k = NFU - 1; k >= 0; k--) begin
        if (ftag[k] == tag) r = {1'b1, fval[k]};
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
      ready_vec[i] = valid_q[i] & payload_q[i][RS1R_BIT] & payload_q[i][RS2R_BIT];
    end
  end

  // Pick the lowest remaining ready slot for each FU in turn.
  always_comb begin
    remaining = ready_vec;
    sel_valid = '0;
    sel_idx   = '0;
    for (int k = 0; k < NFU; k++) begin
      for (int i = NUM_INSTRUCTIONS - 1; i >= 0; i--) begin
        if (remaining[i]) begin
          sel_valid[k] = 1'b1;
          sel_idx[k]   = IDX_W'(i);
        end
      end
      if (sel_valid[k]) remaining[sel_idx[k]] = 1'b0;
    end
  end

  always_comb begin
    free_valid = 1'b0;
    free_idx   = '0;
    for (int i = NUM_INSTRUCTIONS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_valid = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    new_op1 = resolve_operand(iq.phys_rs1, iq.phys_rs1 == '0, iq.phys_rs1_val,
                              iq.fwd_enable, fwd_tag, fwd_val);
    new_op2 = resolve_operand(iq.phys_rs2, iq.phys_rs2 == '0, iq.phys_rs2_val,
                              iq.fwd_enable, fwd_tag, fwd_val);
    new_entry = {iq.phys_rd, iq.phys_rs1, new_op1[31:0], new_op1[32],
                 iq.phys_rs2, new_op2[31:0], new_op2[32],
                 iq.opcode, iq.immediate, iq.ROB_entry_index};
  end

  // Issued slots are freed at the same edge, so forwarding into them is moot.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    enable_d  = '0;
    issued_d  = issued_q;
    cur_op1   = '0;
    cur_op2   = '0;

    for (int i = 0; i < NUM_INSTRUCTIONS; i++) begin
      if (valid_q[i]) begin
        cur_op1 = resolve_operand(payload_q[i][RS1_LSB +: TAG_W], payload_q[i][RS1R_BIT],
                                  payload_q[i][RS1V_LSB +: 32], iq.fwd_enable,
                                  fwd_tag, fwd_val);
        cur_op2 = resolve_operand(payload_q[i][RS2_LSB +: TAG_W], payload_q[i][RS2R_BIT],
                                  payload_q[i][RS2V_LSB +: 32], iq.fwd_enable,
                                  fwd_tag, fwd_val);
        payload_d[i][RS1R_BIT]       = cur_op1[32];
        payload_d[i][RS1V_LSB +: 32] = cur_op1[31:0];
        payload_d[i][RS2R_BIT]       = cur_op2[32];
        payload_d[i][RS2V_LSB +: 32] = cur_op2[31:0];
      end
    end

    for (int k = 0; k < NFU; k++) begin
      if (sel_valid[k]) begin
        valid_d[sel_idx[k]] = 1'b0;
        enable_d[k]         = 1'b1;
        issued_d[k]         = payload_q[sel_idx[k]];
      end
    end

    if (iq.write_enable && free_valid) begin
      valid_d[free_idx]   = 1'b1;
      payload_d[free_idx] = new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      valid_q  <= '0;
      enable_q <= '0;
      for (int k = 0; k < NFU; k++) issued_q[k] <= '0;
    end else begin
      valid_q  <= valid_d;
      enable_q <= enable_d;
      issued_q <= issued_d;
    end
    payload_q <= payload_d;
  end

  assign iq.issued_funct_unit0 = issued_q[0];
  assign iq.issued_funct_unit1 = issued_q[1];
  assign iq.issued_funct_unit2 = issued_q[2];
  assign iq.funct0_enable      = enable_q[0];
  assign iq.funct1_enable      = enable_q[1];
  assign iq.funct2_enable      = enable_q[2];
  assign iq.issue_queue_full   = &valid_q;

endmodule

// File: tb/tb_issue_queue_unit.sv
// Directed bench for issue_queue_unit: stimulus pushes expected issues into a
// scoreboard that a monitor pops whenever any functK_enable is seen.
module tb_issue_queue_unit;

  typedef struct {
    int           cyc;
    int           fu;
    logic [128:0] pl;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   tests_run;
  int   tests_failed;
  exp_t sb[$];

  issue_queue_unit_if iq ();

  issue_queue_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .iq      (iq.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [128:0] pack(
    input logic [5:0] rd, input logic [5:0] rs1, input logic [31:0] v1, input logic r1,
    input logic [5:0] rs2, input logic [31:0] v2, input logic r2,
    input logic [6:0] op, input logic [31:0] imm, input logic [5:0] rob
  );
    return {rd, rs1, v1, r1, rs2, v2, r2, op, imm, rob};
  endfunction

  task automatic checkOutput(input string name, input logic [128:0] act, input logic [128:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setFwd(input logic en,
                        input logic [5:0] t0, input logic [31:0] v0,
                        input logic [5:0] t1, input logic [31:0] v1,
                        input logic [5:0] t2, input logic [31:0] v2);
    iq.fwd_enable             = en;
    iq.fwd_rd_funct_unit0     = t0;
    iq.fwd_rd_val_funct_unit0 = v0;
    iq.fwd_rd_funct_unit1     = t1;
    iq.fwd_rd_val_funct_unit1 = v1;
    iq.fwd_rd_funct_unit2     = t2;
    iq.fwd_rd_val_funct_unit2 = v2;
  endtask

  // Dispatch for exactly one clock edge, then drop the strobe.
  task automatic applyStimulus(input logic [5:0] rd, input logic [5:0] rs1, input logic [5:0] rs2,
                               input logic [31:0] v1, input logic [31:0] v2,
                               input logic [6:0] op, input logic [31:0] imm,
                               input logic [5:0] rob);
    iq.write_enable    = 1'b1;
    iq.phys_rd         = rd;
    iq.phys_rs1        = rs1;
    iq.phys_rs2        = rs2;
    iq.phys_rs1_val    = v1;
    iq.phys_rs2_val    = v2;
    iq.opcode          = op;
    iq.immediate       = imm;
    iq.ROB_entry_index = rob;
    @(negedge clk);
    iq.write_enable    = 1'b0;
  endtask

  task automatic expectIssue(input int at_cyc, input int fu, input logic [128:0] pl);
    exp_t e;
    e.cyc = at_cyc;
    e.fu  = fu;
    e.pl  = pl;
    sb.push_back(e);
  endtask

  // Monitor: every enabled issue port must match the oldest scoreboard entry.
  initial begin
    logic [2:0]   en;
    logic [128:0] bus;
    exp_t         e;
    forever begin
      @(posedge clk);
      #1;
      en = {iq.funct2_enable, iq.funct1_enable, iq.funct0_enable};
      for (int k = 0; k < 3; k++) begin
        if (en[k]) begin
          bus = (k == 0) ? iq.issued_funct_unit0 :
                (k == 1) ? iq.issued_funct_unit1 : iq.issued_funct_unit2;
          tests_run++;
          if (sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL unexpected_issue fu%0d cycle %0d: got %h expected no issue",
                     k, cyc, bus);
          end else begin
            e = sb.pop_front();
            if (e.fu != k || e.cyc != cyc || e.pl !== bus) begin
              tests_failed++;
              $display("[TB] FAIL issue_check: got fu%0d cycle %0d %h expected fu%0d cycle %0d %h",
                       k, cyc, bus, e.fu, e.cyc, e.pl);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] fv [3];
    int          j;
    tests_run    = 0;
    tests_failed = 0;
    fv[0] = 32'h3000_0000;
    fv[1] = 32'h3111_1111;
    fv[2] = 32'h3222_2222;

    reset_n = 1'b1;
    iq.write_enable = 1'b0;
    iq.phys_rd = '0; iq.phys_rs1 = '0; iq.phys_rs2 = '0;
    iq.phys_rs1_val = '0; iq.phys_rs2_val = '0;
    iq.opcode = '0; iq.immediate = '0; iq.ROB_entry_index = '0;
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(2);

    checkOutput("reset_enables", 129'({iq.funct2_enable, iq.funct1_enable, iq.funct0_enable}), 129'd0);
    checkOutput("reset_bus0", iq.issued_funct_unit0, 129'd0);
    checkOutput("reset_bus1", iq.issued_funct_unit1, 129'd0);
    checkOutput("reset_bus2", iq.issued_funct_unit2, 129'd0);
    checkOutput("reset_full", 129'(iq.issue_queue_full), 129'd0);
    reset_n = 1'b0;
    stepCycles(1);

    // Waiting instruction woken by two forwards on different FUs.
    applyStimulus(6'd10, 6'd5, 6'd15, 32'h0, 32'h0, 7'h2A, 32'hDEADBEEF, 6'd20);
    checkOutput("full_after_one", 129'(iq.issue_queue_full), 129'd0);
    stepCycles(1);
    setFwd(1'b1, 6'd5, 32'hCAFEBABE, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(1);
    setFwd(1'b1, 6'd62, 32'h0, 6'd15, 32'hFEEDFACE, 6'd62, 32'h0);
    expectIssue(cyc + 2, 0, pack(6'd10, 6'd5, 32'hCAFEBABE, 1'b1, 6'd15, 32'hFEEDFACE, 1'b1,
                                 7'h2A, 32'hDEADBEEF, 6'd20));
    stepCycles(1);
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(3);

    // Forward during dispatch, all three FUs carrying the same tag: FU0 wins.
    setFwd(1'b1, 6'd7, 32'hA0A0A0A0, 6'd7, 32'hB1B1B1B1, 6'd7, 32'hC2C2C2C2);
    expectIssue(cyc + 2, 0, pack(6'd1, 6'd7, 32'hA0A0A0A0, 1'b1, 6'd0, 32'h11, 1'b1,
                                 7'd1, 32'd1, 6'd1));
    applyStimulus(6'd1, 6'd7, 6'd0, 32'h55, 32'h11, 7'd1, 32'd1, 6'd1);
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(2);

    // FU1 beats FU2 on a stored waiting operand.
    applyStimulus(6'd2, 6'd8, 6'd0, 32'h0, 32'h22, 7'd2, 32'd2, 6'd2);
    setFwd(1'b1, 6'd62, 32'h0, 6'd8, 32'hB1B1B1B1, 6'd8, 32'hC2C2C2C2);
    expectIssue(cyc + 2, 0, pack(6'd2, 6'd8, 32'hB1B1B1B1, 1'b1, 6'd0, 32'h22, 1'b1,
                                 7'd2, 32'd2, 6'd2));
    stepCycles(1);
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(2);

    // Disabled buses ignored; a forward of tag 0 leaves a ready operand alone.
    applyStimulus(6'd3, 6'd9, 6'd0, 32'h0, 32'h11111111, 7'd3, 32'd3, 6'd3);
    setFwd(1'b0, 6'd9, 32'h0BADBAD0, 6'd9, 32'h0BADBAD1, 6'd9, 32'h0BADBAD2);
    stepCycles(2);
    setFwd(1'b1, 6'd0, 32'hBAD0BAD0, 6'd62, 32'h0, 6'd9, 32'h99999999);
    expectIssue(cyc + 2, 0, pack(6'd3, 6'd9, 32'h99999999, 1'b1, 6'd0, 32'h11111111, 1'b1,
                                 7'd3, 32'd3, 6'd3));
    stepCycles(1);
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(2);

    // Ready-at-dispatch latency, then three slots becoming ready together.
    expectIssue(cyc + 2, 0, pack(6'd4, 6'd0, 32'hAAAA0004, 1'b1, 6'd0, 32'hBBBB0004, 1'b1,
                                 7'd4, 32'd4, 6'd4));
    applyStimulus(6'd4, 6'd0, 6'd0, 32'hAAAA0004, 32'hBBBB0004, 7'd4, 32'd4, 6'd4);
    stepCycles(3);
    for (int k = 0; k < 3; k++)
      applyStimulus(6'(5 + k), 6'd0, 6'd40, 32'(32'h100 + k), 32'h0, 7'd5, 32'(5 + k), 6'(5 + k));
    setFwd(1'b1, 6'd62, 32'h0, 6'd40, 32'h40404040, 6'd62, 32'h0);
    for (int k = 0; k < 3; k++)
      expectIssue(cyc + 2, k, pack(6'(5 + k), 6'd0, 32'(32'h100 + k), 1'b1, 6'd40, 32'h40404040,
                                   1'b1, 7'd5, 32'(5 + k), 6'(5 + k)));
    stepCycles(1);
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(3);

    // Fill all 64 slots with waiting instructions; the 65th is dropped.
    for (int i = 0; i < 64; i++)
      applyStimulus(6'(i), 6'(30 + i % 3), (i % 4 == 3) ? 6'd50 : 6'd31, 32'h0, 32'h0,
                    7'h33, 32'(32'h1000 + i), 6'(i));
    checkOutput("full_after_64", 129'(iq.issue_queue_full), 129'd1);
    applyStimulus(6'd63, 6'd0, 6'd0, 32'h0, 32'h0, 7'h7F, 32'hFFFF, 6'd63);
    checkOutput("full_after_drop", 129'(iq.issue_queue_full), 129'd1);
    stepCycles(2);

    // Wake 48 entries at once: three per cycle in ascending slot order.
    setFwd(1'b1, 6'd30, fv[0], 6'd31, fv[1], 6'd32, fv[2]);
    j = 0;
    for (int i = 0; i < 64; i++) begin
      if (i % 4 != 3) begin
        expectIssue(cyc + 2 + j / 3, j % 3,
                    pack(6'(i), 6'(30 + i % 3), fv[i % 3], 1'b1, 6'd31, fv[1], 1'b1,
                         7'h33, 32'(32'h1000 + i), 6'(i)));
        j++;
      end
    end
    stepCycles(1);
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(1);
    checkOutput("full_after_issue", 129'(iq.issue_queue_full), 129'd0);
    stepCycles(20);

    // Refill to full, then reset with dispatch and forwarding active.
    for (int i = 0; i < 48; i++)
      applyStimulus(6'(i), 6'd50, 6'd50, 32'h0, 32'h0, 7'h44, 32'(i), 6'(i));
    checkOutput("full_refill", 129'(iq.issue_queue_full), 129'd1);
    reset_n = 1'b1;
    iq.write_enable = 1'b1;
    iq.phys_rs1 = 6'd0;
    iq.phys_rs2 = 6'd0;
    setFwd(1'b1, 6'd50, 32'h5050, 6'd50, 32'h5151, 6'd50, 32'h5252);
    stepCycles(1);
    checkOutput("reset_mid_full", 129'(iq.issue_queue_full), 129'd0);
    checkOutput("reset_mid_enables",
                129'({iq.funct2_enable, iq.funct1_enable, iq.funct0_enable}), 129'd0);
    reset_n = 1'b0;
    iq.write_enable = 1'b0;
    stepCycles(2);
    setFwd(1'b0, 6'd62, 32'h0, 6'd62, 32'h0, 6'd62, 32'h0);
    stepCycles(4);

    expectIssue(cyc + 2, 0, pack(6'd9, 6'd0, 32'h9, 1'b1, 6'd0, 32'h99, 1'b1,
                                 7'h09, 32'h9, 6'd9));
    applyStimulus(6'd9, 6'd0, 6'd0, 32'h9, 32'h99, 7'h09, 32'h9, 6'd9);
    stepCycles(4);

    checkOutput("scoreboard_drained", 129'(sb.size()), 129'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
